// File: rtl/exec_pkg.sv
// exec_pkg: shared constants and bundles for the execute stage.
// funct3 codes, ctrl_i bit layout, reset PC and the output register bundle.
package exec_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // Field order fixes the ctrl_i bit positions, MSB first.
  typedef struct packed {
    logic alu_src_imm;
    logic sub_sra;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] waddr;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] result;
    logic [4:0]      dest;
    logic [1:0]      raddr;
    logic [2:0]      aluop;
    logic            branch_stall;
    logic            branch_taken;
    logic            mem_write;
    logic            alu_to_reg;
    logic            mem_to_reg;
  } ex_out_t;

endpackage

// File: rtl/exec_if.sv
// exec_if: decode-to-execute inputs and execute-to-writeback outputs.
// master drives the decoded instruction, slave is the execute stage.
interface exec_if;
  import exec_pkg::*;

  logic            stall_read_i;
  logic            dec_valid_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [4:0]      rs1_sel_i;
  logic [4:0]      rs2_sel_i;
  logic [4:0]      dest_sel_i;
  logic [XLEN-1:0] imm_i;
  logic [2:0]      alu_op_i;
  logic [8:0]      ctrl_i;
  logic            reg_write_i;

  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] alu_operand1_o;
  logic [XLEN-1:0] alu_operand2_o;
  logic [XLEN-1:0] write_address_o;
  logic [XLEN-1:0] next_pc_o;
  logic [XLEN-1:0] wb_result_o;
  logic            branch_stall_o;
  logic            branch_taken_o;
  logic            mem_write_o;
  logic            wb_alu_to_reg_o;
  logic            wb_mem_to_reg_o;
  logic            wb_branch_o;
  logic            wb_branch_nxt_o;
  logic [4:0]      wb_dest_reg_sel_o;
  logic [1:0]      wb_read_address_o;
  logic [2:0]      wb_alu_operation_o;

  modport master (
    output stall_read_i, dec_valid_i, pc_i,
    output rs1_data_i, rs2_data_i,
    output rs1_sel_i, rs2_sel_i, dest_sel_i,
    output imm_i, alu_op_i, ctrl_i, reg_write_i,
    input  pc_o, alu_operand1_o, alu_operand2_o,
    input  write_address_o, next_pc_o, wb_result_o,
    input  branch_stall_o, branch_taken_o, mem_write_o,
    input  wb_alu_to_reg_o, wb_mem_to_reg_o,
    input  wb_branch_o, wb_branch_nxt_o,
    input  wb_dest_reg_sel_o, wb_read_address_o,
    input  wb_alu_operation_o
  );

  modport slave (
    input  stall_read_i, dec_valid_i, pc_i,
    input  rs1_data_i, rs2_data_i,
    input  rs1_sel_i, rs2_sel_i, dest_sel_i,
    input  imm_i, alu_op_i, ctrl_i, reg_write_i,
    output pc_o, alu_operand1_o, alu_operand2_o,
    output write_address_o, next_pc_o, wb_result_o,
    output branch_stall_o, branch_taken_o, mem_write_o,
    output wb_alu_to_reg_o, wb_mem_to_reg_o,
    output wb_branch_o, wb_branch_nxt_o,
    output wb_dest_reg_sel_o, wb_read_address_o,
    output wb_alu_operation_o
  );
endinterface

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU and branch comparator for the execute stage.
// The comparator always compares rs1 against rs2, never the immediate.
module exec_alu
  import exec_pkg::*;
(
  input  logic [2:0]      op_i,
  input  logic            sub_sra_i,
  input  logic            use_imm_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] res_o,
  output logic            cond_o
);

  logic [4:0] sh;
  logic       eq, lt, ltu;

  assign sh  = b_i[4:0];
  assign eq  = a_i == rs2_i;
  assign lt  = $signed(a_i) < $signed(rs2_i);
  assign ltu = a_i < rs2_i;

  always_comb begin
    res_o = '0;
    case (op_i)
      F3_ADD: begin
        if (sub_sra_i && !use_imm_i) res_o = a_i - b_i;
        else res_o = a_i + b_i;
      end
      F3_SLL:  res_o = a_i << sh;
      F3_SLT:  res_o = {31'b0, $signed(a_i) < $signed(b_i)};
      F3_SLTU: res_o = {31'b0, a_i < b_i};
      F3_XOR:  res_o = a_i ^ b_i;
      F3_SR: begin
        if (sub_sra_i) res_o = $signed(a_i) >>> sh;
        else res_o = a_i >> sh;
      end
      F3_OR:   res_o = a_i | b_i;
      F3_AND:  res_o = a_i & b_i;
    endcase
  end

  always_comb begin
    cond_o = 1'b0;
    case (op_i)
      BR_EQ:   cond_o = eq;
      BR_NE:   cond_o = !eq;
      BR_LT:   cond_o = lt;
      BR_GE:   cond_o = !lt;
      BR_LTU:  cond_o = ltu;
      BR_GEU:  cond_o = !ltu;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// execute: registered ALU/branch stage with one-cycle squash after taken branches.
// Define EXEC_FWD_EN to bypass the registered ALU result into the operands.
module execute
  import exec_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET = RESET_PC
) (
  input logic   clk,
  input logic   reset,
  exec_if.slave bus
);

  ctrl_t           c;
  ex_out_t         out_d, out_q;
  logic [XLEN-1:0] rs1, rs2, op2, alu_res;
  logic [XLEN-1:0] pc4, pc_imm, ea;
  logic            cond, br_tk, live;

  assign c = ctrl_t'(bus.ctrl_i);

`ifdef EXEC_FWD_EN
  logic fwd1, fwd2;
  assign fwd1 = out_q.alu_to_reg && bus.rs1_sel_i != 5'd0
             && out_q.dest == bus.rs1_sel_i;
  assign fwd2 = out_q.alu_to_reg && bus.rs2_sel_i != 5'd0
             && out_q.dest == bus.rs2_sel_i;
  assign rs1  = fwd1 ? out_q.result : bus.rs1_data_i;
  assign rs2  = fwd2 ? out_q.result : bus.rs2_data_i;
`else
  logic unused_sel;
  assign unused_sel = ^{bus.rs1_sel_i, bus.rs2_sel_i};
  assign rs1 = bus.rs1_data_i;
  assign rs2 = bus.rs2_data_i;
`endif

  assign op2    = c.alu_src_imm ? bus.imm_i : rs2;
  assign pc4    = bus.pc_i + 32'd4;
  assign pc_imm = bus.pc_i + bus.imm_i;
  assign ea     = rs1 + bus.imm_i;
  assign br_tk  = c.branch & cond;
  // A taken branch last cycle squashes whatever is captured now.
  assign live   = bus.dec_valid_i & ~out_q.branch_taken;

  exec_alu u_alu (
    .op_i      (bus.alu_op_i),
    .sub_sra_i (c.sub_sra),
    .use_imm_i (c.alu_src_imm),
    .a_i       (rs1),
    .b_i       (op2),
    .rs2_i     (rs2),
    .res_o     (alu_res),
    .cond_o    (cond)
  );

  always_comb begin
    out_d         = '0;
    out_d.pc      = bus.pc_i;
    out_d.op1     = rs1;
    out_d.op2     = op2;
    out_d.waddr   = ea;
    out_d.raddr   = ea[1:0];
    out_d.aluop   = bus.alu_op_i;
    out_d.dest    = bus.dest_sel_i;
    out_d.next_pc = pc4;
    out_d.result  = alu_res;
    unique case (1'b1)
      c.jalr:       out_d.next_pc = ea & ~32'd1;
      c.jal, br_tk: out_d.next_pc = pc_imm;
      default:      out_d.next_pc = pc4;
    endcase
    unique case (1'b1)
      c.jal, c.jalr: out_d.result = pc4;
      c.lui:         out_d.result = bus.imm_i;
      c.auipc:       out_d.result = pc_imm;
      default:       out_d.result = alu_res;
    endcase
    out_d.branch_stall = out_q.branch_taken;
    out_d.branch_taken = live & (br_tk | c.jal | c.jalr);
    out_d.mem_write    = live & c.mem_write;
    out_d.mem_to_reg   = live & c.mem_read;
    out_d.alu_to_reg   = live & bus.reg_write_i & ~c.mem_read
                       & (bus.dest_sel_i != 5'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q         <= '0;
      out_q.pc      <= RESET;
      out_q.next_pc <= RESET;
    end else if (!bus.stall_read_i) begin
      out_q <= out_d;
    end
  end

  assign bus.pc_o               = out_q.pc;
  assign bus.alu_operand1_o     = out_q.op1;
  assign bus.alu_operand2_o     = out_q.op2;
  assign bus.write_address_o    = out_q.waddr;
  assign bus.next_pc_o          = out_q.next_pc;
  assign bus.wb_result_o        = out_q.result;
  assign bus.branch_stall_o     = out_q.branch_stall;
  assign bus.branch_taken_o     = out_q.branch_taken;
  assign bus.mem_write_o        = out_q.mem_write;
  assign bus.wb_alu_to_reg_o    = out_q.alu_to_reg;
  assign bus.wb_mem_to_reg_o    = out_q.mem_to_reg;
  assign bus.wb_branch_o        = out_q.branch_taken;
  assign bus.wb_branch_nxt_o    = out_q.branch_stall;
  assign bus.wb_dest_reg_sel_o  = out_q.dest;
  assign bus.wb_read_address_o  = out_q.raddr;
  assign bus.wb_alu_operation_o = out_q.aluop;

endmodule

// File: tb/tb_execute.sv
// tb_execute: directed and randomized checks of execute against a reference model.
// Define EXEC_FWD_EN to check the bypass build.
module tb_execute;

  localparam logic [31:0] RST = 32'h0000_1000;
  localparam int K_IMM = 8, K_SUB = 7, K_BR = 6, K_JAL = 5, K_JALR = 4;
  localparam int K_LUI = 3, K_AUIPC = 2, K_MR = 1, K_MW = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  exec_if bus();

  execute #(.RESET(RST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] m_pc, m_op1, m_op2, m_wa, m_npc, m_res;
  logic        m_bs, m_bt, m_mw, m_a2r, m_m2r;
  logic [4:0]  m_dst;
  logic [1:0]  m_ra;
  logic [2:0]  m_aop;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".pc"},   bus.pc_o, m_pc);
    chk({t, ".op1"},  bus.alu_operand1_o, m_op1);
    chk({t, ".op2"},  bus.alu_operand2_o, m_op2);
    chk({t, ".wa"},   bus.write_address_o, m_wa);
    chk({t, ".npc"},  bus.next_pc_o, m_npc);
    chk({t, ".res"},  bus.wb_result_o, m_res);
    chk({t, ".bs"},   {31'b0, bus.branch_stall_o}, {31'b0, m_bs});
    chk({t, ".bt"},   {31'b0, bus.branch_taken_o}, {31'b0, m_bt});
    chk({t, ".mw"},   {31'b0, bus.mem_write_o}, {31'b0, m_mw});
    chk({t, ".a2r"},  {31'b0, bus.wb_alu_to_reg_o}, {31'b0, m_a2r});
    chk({t, ".m2r"},  {31'b0, bus.wb_mem_to_reg_o}, {31'b0, m_m2r});
    chk({t, ".wbb"},  {31'b0, bus.wb_branch_o}, {31'b0, m_bt});
    chk({t, ".wbn"},  {31'b0, bus.wb_branch_nxt_o}, {31'b0, m_bs});
    chk({t, ".dst"},  {27'b0, bus.wb_dest_reg_sel_o}, {27'b0, m_dst});
    chk({t, ".ra"},   {30'b0, bus.wb_read_address_o}, {30'b0, m_ra});
    chk({t, ".aop"},  {29'b0, bus.wb_alu_operation_o}, {29'b0, m_aop});
  endtask

  task automatic model_reset();
    m_pc = RST; m_npc = RST;
    m_op1 = 0; m_op2 = 0; m_wa = 0; m_res = 0;
    m_bs = 0; m_bt = 0; m_mw = 0; m_a2r = 0; m_m2r = 0;
    m_dst = 0; m_ra = 0; m_aop = 0;
  endtask

  task automatic model_step();
    logic [31:0] a, r2, b, r, sa, sb, ea, pc, imm;
    logic [8:0]  k;
    logic        cond, jump, live;
    int          sh;
    if (bus.stall_read_i) return;
    k = bus.ctrl_i; pc = bus.pc_i; imm = bus.imm_i;
    a = bus.rs1_data_i; r2 = bus.rs2_data_i;
`ifdef EXEC_FWD_EN
    if (m_a2r && bus.rs1_sel_i != 0 && bus.rs1_sel_i == m_dst) a = m_res;
    if (m_a2r && bus.rs2_sel_i != 0 && bus.rs2_sel_i == m_dst) r2 = m_res;
`endif
    b = k[K_IMM] ? imm : r2;
    sh = int'(b[4:0]);
    sa = a ^ 32'h8000_0000;
    case (bus.alu_op_i)
      3'd0: r = (k[K_SUB] && !k[K_IMM]) ? a + (~b + 32'd1) : a + b;
      3'd1: r = a << sh;
      3'd2: r = (sa < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a >> sh;
        if (k[K_SUB] && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    sb = r2 ^ 32'h8000_0000;
    case (bus.alu_op_i)
      3'd0: cond = (a == r2);
      3'd1: cond = (a != r2);
      3'd4: cond = (sa < sb);
      3'd5: cond = !(sa < sb);
      3'd6: cond = (a < r2);
      3'd7: cond = !(a < r2);
      default: cond = 1'b0;
    endcase
    ea = a + imm;
    jump = (k[K_BR] && cond) || k[K_JAL];
    live = bus.dec_valid_i && !m_bt;
    if (k[K_JALR]) m_npc = {ea[31:1], 1'b0};
    else if (jump) m_npc = pc + imm;
    else m_npc = pc + 32'd4;
    if (k[K_JAL] || k[K_JALR]) m_res = pc + 32'd4;
    else if (k[K_LUI]) m_res = imm;
    else if (k[K_AUIPC]) m_res = pc + imm;
    else m_res = r;
    m_bs  = m_bt;
    m_bt  = live && (jump || k[K_JALR]);
    m_mw  = live && k[K_MW];
    m_m2r = live && k[K_MR];
    m_a2r = live && bus.reg_write_i && !k[K_MR] && bus.dest_sel_i != 0;
    m_pc = pc; m_op1 = a; m_op2 = b; m_wa = ea; m_ra = ea[1:0];
    m_dst = bus.dest_sel_i; m_aop = bus.alu_op_i;
  endtask

  task automatic set_idle();
    bus.stall_read_i = 0; bus.dec_valid_i = 0; bus.pc_i = 0;
    bus.rs1_data_i = 0; bus.rs2_data_i = 0;
    bus.rs1_sel_i = 0; bus.rs2_sel_i = 0; bus.dest_sel_i = 0;
    bus.imm_i = 0; bus.alu_op_i = 0; bus.ctrl_i = 0; bus.reg_write_i = 0;
  endtask

  task automatic rand_instr();
    logic [8:0] k;
    int cls;
    cls = $urandom_range(0, 8);
    k = '0;
    bus.pc_i = {$urandom_range(0, 16'hFFFF), 2'b00};
    bus.rs1_data_i = $urandom;
    bus.rs2_data_i = ($urandom_range(0, 2) == 0) ? bus.rs1_data_i : $urandom;
    bus.rs1_sel_i = 5'($urandom_range(0, 3));
    bus.rs2_sel_i = 5'($urandom_range(0, 3));
    bus.dest_sel_i = 5'($urandom_range(0, 3));
    bus.imm_i = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 63));
    bus.alu_op_i = 3'($urandom_range(0, 7));
    bus.reg_write_i = 1;
    k[K_SUB] = 1'($urandom_range(0, 1));
    case (cls)
      0: ;
      1: k[K_IMM] = 1;
      2: begin k[K_BR] = 1; bus.reg_write_i = 0; end
      3: k[K_JAL] = 1;
      4: k[K_JALR] = 1;
      5: k[K_LUI] = 1;
      6: k[K_AUIPC] = 1;
      7: begin k[K_IMM] = 1; k[K_MR] = 1; end
      default: begin k[K_IMM] = 1; k[K_MW] = 1; bus.reg_write_i = 0; end
    endcase
    bus.ctrl_i = k;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held_pc;
    set_idle();
    #1 reset = 1'b0;
    #1 model_reset();
    check_all("rst");
    @(negedge clk) reset = 1'b1;

    // add x3 = 7 + 5
    bus.dec_valid_i = 1; bus.rs1_data_i = 7; bus.rs2_data_i = 5;
    bus.rs1_sel_i = 5; bus.rs2_sel_i = 6; bus.dest_sel_i = 3;
    bus.reg_write_i = 1;
    tick();
    check_all("add");
    chk("add.sum", bus.wb_result_o, 32'd12);
    chk("add.wr", {31'b0, bus.wb_alu_to_reg_o}, 32'd1);

    // beq taken, then a store that must be squashed
    set_idle(); bus.dec_valid_i = 1;
    bus.rs1_data_i = 3; bus.rs2_data_i = 3; bus.pc_i = 32'h100;
    bus.imm_i = 32'h20; bus.ctrl_i = 9'(1 << K_BR);
    tick();
    check_all("beq");
    chk("beq.npc", bus.next_pc_o, 32'h120);
    chk("beq.bt", {31'b0, bus.branch_taken_o}, 32'd1);
    bus.ctrl_i = 9'((1 << K_IMM) | (1 << K_MW)); bus.pc_i = 32'h104;
    tick();
    check_all("sq");
    chk("sq.bs", {31'b0, bus.branch_stall_o}, 32'd1);
    chk("sq.mw", {31'b0, bus.mem_write_o}, 32'd0);
    tick();
    check_all("st");
    chk("st.mw", {31'b0, bus.mem_write_o}, 32'd1);
    chk("st.bs", {31'b0, bus.branch_stall_o}, 32'd0);

    // stall holds for three cycles of changing inputs
    held_pc = m_pc;
    bus.stall_read_i = 1;
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      tick();
      check_all("stall");
      chk("stall.pc", bus.pc_o, held_pc);
    end

    // sra with immediate shamt 0x24 -> shift by 4
    set_idle(); bus.dec_valid_i = 1;
    bus.rs1_data_i = 32'h8000_0000; bus.imm_i = 32'h24;
    bus.ctrl_i = 9'((1 << K_IMM) | (1 << K_SUB));
    bus.alu_op_i = 3'b101; bus.reg_write_i = 1; bus.dest_sel_i = 4;
    tick();
    check_all("sra");
    chk("sra.res", bus.wb_result_o, 32'hF800_0000);

    // async reset while branch_stall_o is high
    set_idle(); bus.dec_valid_i = 1; bus.pc_i = 32'h200;
    bus.imm_i = 32'h40; bus.ctrl_i = 9'(1 << K_BR);
    tick();
    chk("arb.bt", {31'b0, bus.branch_taken_o}, 32'd1);
    bus.ctrl_i = 0; bus.reg_write_i = 1; bus.dest_sel_i = 7;
    tick();
    chk("arb.bs", {31'b0, bus.branch_stall_o}, 32'd1);
    reset = 1'b0;
    #1 model_reset();
    check_all("arst");
    chk("arst.pc", bus.pc_o, RST);
    @(posedge clk);
    #1 check_all("arst_hold");
    set_idle();
    @(negedge clk) reset = 1'b1;
    tick();
    check_all("rel");

    // addi x1 = x0 + 10, then add x2 = x1 + x1
    bus.dec_valid_i = 1; bus.imm_i = 10; bus.ctrl_i = 9'(1 << K_IMM);
    bus.reg_write_i = 1; bus.dest_sel_i = 1;
    tick();
    check_all("addi");
    bus.ctrl_i = 0; bus.rs1_sel_i = 1; bus.rs2_sel_i = 1;
    bus.rs1_data_i = 100; bus.rs2_data_i = 100; bus.dest_sel_i = 2;
    tick();
    check_all("fwd");
`ifdef EXEC_FWD_EN
    chk("fwd.sum", bus.wb_result_o, 32'd20);
`else
    chk("fwd.sum", bus.wb_result_o, 32'd200);
`endif

    for (int n = 0; n < 400; n++) begin
      rand_instr();
      bus.stall_read_i = ($urandom_range(0, 7) == 0);
      bus.dec_valid_i = ($urandom_range(0, 7) != 0);
      tick();
      check_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have parameter RESET, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall_read_i  input  1  writeback stall; holds all execute output registers.
REQ-005 SHALL have port dec_valid_i  input  1  decoded instruction present.
REQ-006 SHALL have port pc_i  input  32  PC of decoded instruction.
REQ-007 SHALL have port rs1_data_i / rs2_data_i  input  32 each  register-file operands.
REQ-008 SHALL have port rs1_sel_i / rs2_sel_i / dest_sel_i  input  5 each  source and destination register indices.
REQ-009 SHALL have port imm_i  input  32  sign-extended immediate.
REQ-010 SHALL have port alu_op_i  input  3  funct3 code.
REQ-011 SHALL have port ctrl_i  input  9  {alu_src_imm, sub_sra, branch, jal, jalr, lui, auipc, mem_read, mem_write}.
REQ-012 SHALL have port reg_write_i  input  1  instruction writes rd.
REQ-013 SHALL have outputs pc_o, alu_operand1_o, alu_operand2_o, write_address_o, next_pc_o, wb_result_o  output  32 each  registered PC, operands, memory address, successor PC and result.
REQ-014 SHALL have outputs branch_stall_o, branch_taken_o, mem_write_o, wb_alu_to_reg_o, wb_mem_to_reg_o, wb_branch_o, wb_branch_nxt_o  output  1 each  registered control flags.
REQ-015 SHALL have outputs wb_dest_reg_sel_o  output  5, wb_read_address_o  output  2, wb_alu_operation_o  output  3  registered writeback metadata.

Function
REQ-016 SHALL register all outputs: one-cycle latency from inputs to outputs.
REQ-017 SHALL hold every output register unchanged while stall_read_i=1; stall wins over any simultaneous branch, valid or squash event.
REQ-018 SHALL compute ALU per funct3: 000 add/sub (sub if sub_sra and not imm), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and. Arithmetic wraps mod 2^32; shift amount = operand2[4:0].
REQ-019 SHALL select operand2 = imm_i when alu_src_imm, else rs2 data.
REQ-020 SHALL set wb_result_o: pc+4 for jal/jalr, imm for lui, pc+imm for auipc, ALU result otherwise.
REQ-021 SHALL set write_address_o = rs1+imm; wb_read_address_o = its bits [1:0]; wb_alu_operation_o = alu_op_i.
REQ-022 SHALL evaluate branch conditions beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111 (010/011 never taken).
REQ-023 SHALL set next_pc_o: pc+imm for taken branch or jal; (rs1+imm)&~1 for jalr; pc+4 otherwise; branch_taken_o=1 in the first two cases and for jalr.
REQ-024 SHALL set branch_stall_o=1 for exactly the cycle after branch_taken_o=1, squashing the instruction captured in that cycle: mem_write_o, wb_alu_to_reg_o, wb_mem_to_reg_o and branch_taken_o are forced to 0.
REQ-025 SHALL insert a bubble when dec_valid_i=0: mem_write_o, wb_alu_to_reg_o, wb_mem_to_reg_o, branch_taken_o=0, pc_o updated.
REQ-026 SHALL set wb_alu_to_reg_o = reg_write_i and not mem_read; wb_mem_to_reg_o = mem_read; wb_branch_o = branch_taken_o; wb_branch_nxt_o = branch_stall_o.
REQ-027 SHALL never assert wb_alu_to_reg_o for dest_sel_i=0.

Reset
REQ-028 SHALL, while reset=0, asynchronously force pc_o = next_pc_o = RESET and all other outputs to 0, including mid-instruction and mid-squash.
REQ-029 SHALL resume capturing on the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL, with EXEC_FWD_EN defined, bypass wb_result_o into rs1/rs2 operands when wb_alu_to_reg_o=1 and wb_dest_reg_sel_o equals the non-zero source index.
REQ-031 SHALL, without EXEC_FWD_EN, use rs1_data_i/rs2_data_i directly; ports are identical in both builds.

Structure
REQ-032 SHALL take funct3 ALU/branch codes, ctrl_i bit positions and the default RESET constant from shared package exec_pkg.
REQ-033 SHALL place ALU and comparator in one combinational sub-module exec_alu.

Verification
REQ-034 SHALL test add: rs1=7, rs2=5, op 000 -> one cycle later wb_result_o=12, wb_alu_to_reg_o=1.
REQ-035 SHALL test beq: rs1=rs2=3, pc=0x100, imm=0x20 -> next_pc_o=0x120, branch_taken_o=1; next cycle branch_stall_o=1 and a store is squashed (mem_write_o=0).
REQ-036 SHALL test stall: stall_read_i=1 for 3 cycles with changing inputs -> all outputs unchanged.
REQ-037 SHALL test sra: rs1=0x80000000, imm shamt=0x24, sub_sra=1 -> wb_result_o=0xF8000000 (shamt 4).
REQ-038 SHALL test reset mid-branch: reset=0 while branch_stall_o=1 -> pc_o=RESET, all flags 0 immediately.
REQ-039 SHALL test forwarding: back-to-back addi x1, then add x2=x1+x1 -> EXEC_FWD_EN gives forwarded sum; without it, gives rs1_data_i sum.
